// File: rtl/clk_divider_multi_if.sv
// Control/status bundle for clk_divider_multi: per-channel enables, the divisor
// write port, and the per-channel square-wave, tick and pending flags.
interface clk_divider_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 14,
  // One spare code above the last channel so out-of-range addresses can be expressed.
  parameter int CH_W     = ($clog2(CHANNELS + 1) > 1) ? $clog2(CHANNELS + 1) : 1
);
  logic [CHANNELS-1:0] en_in;
  logic                wr_en_in;
  logic [CH_W-1:0]     wr_chan_in;
  logic [CNT_W-1:0]    wr_div_in;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick_out;
  logic [CHANNELS-1:0] pend_out;

  modport master (
    output en_in, wr_en_in, wr_chan_in, wr_div_in,
    input  clk_out, tick_out, pend_out
  );

  modport slave (
    input  en_in, wr_en_in, wr_chan_in, wr_div_in,
    output clk_out, tick_out, pend_out
  );
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable square-wave / tick generator.
// Each channel counts 0..active, toggling its output at every wrap, so a half
// period is active+1 cycles. New divisors land in a shadow register and only
// become active at a wrap (or while the channel is disabled), so a half period
// in progress always completes with the divisor it started with.
module clk_divider_multi #(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = 14,
  parameter int unsigned DEFAULT_DIV = 8332
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  clk_divider_multi_if.slave   bus
);
  // Wide enough to encode CHANNELS itself, so writes past the last channel can be rejected.
  localparam int CH_W = ($clog2(CHANNELS + 1) > 1) ? $clog2(CHANNELS + 1) : 1;
  localparam logic [CNT_W-1:0] LP_DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    r_cnt    [CHANNELS];
  logic [CNT_W-1:0]    r_shadow [CHANNELS];
  logic [CNT_W-1:0]    r_active [CHANNELS];
  logic [CHANNELS-1:0] r_clk;
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_pend;

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_wrap;
  logic [CNT_W-1:0]    w_next_active [CHANNELS];

  // Write address decode, wrap detect, and the divisor to load at the next reload point.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i]         = bus.wr_en_in && (bus.wr_chan_in == CH_W'(i));
      w_wrap[i]        = (r_cnt[i] == r_active[i]);
      // A write landing in the reload cycle goes straight to active.
      w_next_active[i] = w_hit[i] ? bus.wr_div_in : r_shadow[i];
    end
  end

  // Per-channel counter, output toggle, tick and shadow/active divisor handling.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset_in) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= LP_DEF_DIV;
        r_active[i] <= LP_DEF_DIV;
        r_clk[i]    <= 1'b0;
        r_tick[i]   <= 1'b0;
        r_pend[i]   <= 1'b0;
      end else begin
        if (w_hit[i]) begin
          r_shadow[i] <= bus.wr_div_in;
        end
        if (!bus.en_in[i]) begin
          r_cnt[i]    <= '0;
          r_clk[i]    <= 1'b0;
          r_tick[i]   <= 1'b0;
          r_active[i] <= w_next_active[i];
          r_pend[i]   <= 1'b0;
        end else if (w_wrap[i]) begin
          r_cnt[i]    <= '0;
          r_clk[i]    <= ~r_clk[i];
          // Tick only on the low-to-high transition.
          r_tick[i]   <= ~r_clk[i];
          r_active[i] <= w_next_active[i];
          r_pend[i]   <= 1'b0;
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
          if (w_hit[i]) begin
            r_pend[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.clk_out  = r_clk;
  assign bus.tick_out = r_tick;
  assign bus.pend_out = r_pend;
endmodule
